gsim_x_collector: RTL and testbench

- Sits directly downstream of the Gauss-Seidel solver core.
- Captures the 16-word solution frame the solver emits on its x_out/out_valid pair into a local buffer.
- Replays the captured frame to a consumer over a valid/ready stream with word index and last marker.
- Keeps a frame counter and a sticky overflow flag for system monitoring.

---
 rtl/gsim_x_collector_if.sv | 30 +++
 rtl/gsim_x_collector.sv | 98 +++++++++
 tb/tb_gsim_x_collector.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsim_x_collector_if.sv
// Output stream of the solution-frame collector:
// word, index and last marker under a valid/ready handshake.
interface gsim_x_collector_if #(
  parameter int N = 16,
  parameter int W = 32
);
  localparam int AW = $clog2(N);

  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [AW-1:0] m_index;
  logic          m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_index,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_index,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/gsim_x_collector.sv
// Captures one N-word Gauss-Seidel solution frame,
// then replays it over a valid/ready stream.
module gsim_x_collector #(
  parameter int N = 16,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  gsim_x_collector_if.master       m,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     ovf_err,
  output logic [7:0]               frame_cnt
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_e;

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic          m_valid_q;
  logic          frame_done_q;
  logic          ovf_q;
  logic [7:0]    cnt_q;
  logic [W-1:0]  buf_q [N];

  // Buffer is never written in DRAIN, so data holds while stalled
  assign m.m_valid = m_valid_q;
  assign m.m_data  = buf_q[rd_ptr_q];
  assign m.m_index = rd_ptr_q;
  assign m.m_last  = m_valid_q && (rd_ptr_q == LAST);

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign ovf_err    = ovf_q;
  assign frame_cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            buf_q[0] <= in_data;
            wr_ptr_q <= AW'(1);
            state_q  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (in_valid) begin
            buf_q[wr_ptr_q] <= in_data;
            if (wr_ptr_q == LAST) begin
              wr_ptr_q     <= '0;
              rd_ptr_q     <= '0;
              m_valid_q    <= 1'b1;
              frame_done_q <= 1'b1;
              state_q      <= DRAIN;
              if (cnt_q != 8'hFF)
                cnt_q <= cnt_q + 8'd1;
            end else begin
              wr_ptr_q <= wr_ptr_q + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (in_valid)
            ovf_q <= 1'b1;
          if (m.m_ready) begin
            if (rd_ptr_q == LAST) begin
              rd_ptr_q  <= '0;
              m_valid_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              rd_ptr_q <= rd_ptr_q + AW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gsim_x_collector.sv
// Directed bench for gsim_x_collector: capture, replay,
// stalls, gaps, overflow, reset and counter saturation.
module tb_gsim_x_collector;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        busy;
  logic        frame_done;
  logic        ovf_err;
  logic [7:0]  frame_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [16];

  gsim_x_collector_if #(.N(16), .W(32)) sif ();

  gsim_x_collector #(.N(16), .W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .m          (sif.master),
    .busy       (busy),
    .frame_done (frame_done),
    .ovf_err    (ovf_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    sif.m_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] word(input int mode, input int k);
    case (mode)
      0:       return 32'h0001_0000 * 32'(k);
      1:       return 32'hFFFF_0000 - 32'(k);
      default: return 32'h1234_0000 + 32'(k);
    endcase
  endfunction

  // Drives one frame; word 15 lands on the last edge
  task automatic capture_frame(input int mode, input bit gaps);
    int k;
    int ncyc;
    bit v;
    k = 0;
    ncyc = gaps ? 31 : 16;
    for (int c = 0; c < ncyc; c++) begin
      v = gaps ? (c % 2 == 0) : 1'b1;
      in_valid = v;
      in_data = 32'hA5A5_A5A5;
      if (v) begin
        exp_q[k] = word(mode, k);
        in_data = exp_q[k];
        k++;
      end
      step();
      checks++;
      if (c < ncyc - 1) begin
        if (sif.m_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL capture c=%0d: m_valid=%b frame_done=%b busy=%b, need 0 0 1",
                   c, sif.m_valid, frame_done, busy);
        end
      end else begin
        if (sif.m_valid !== 1'b1 || frame_done !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL capture_end: m_valid=%b frame_done=%b busy=%b, need 1 1 1",
                   sif.m_valid, frame_done, busy);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_frame(input bit stall, input bit fd_first, input bit inj_last);
    logic [3:0] pat;
    int idx;
    int cyc;
    bit rdy;
    pat = 4'b1001;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      rdy = stall ? pat[cyc % 4] : 1'b1;
      sif.m_ready = rdy;
      in_valid = inj_last && (idx == 15);
      in_data = 32'hDEAD_BEEF;
      checks++;
      if (sif.m_valid !== 1'b1 || sif.m_index !== 4'(idx) ||
          sif.m_data !== exp_q[idx] || sif.m_last !== (idx == 15) ||
          frame_done !== (fd_first && cyc == 0)) begin
        errors++;
        $display("FAIL drain cyc=%0d: v=%b idx=%0d data=%h last=%b fd=%b, need 1 %0d %h %b %b",
                 cyc, sif.m_valid, sif.m_index, sif.m_data, sif.m_last, frame_done,
                 idx, exp_q[idx], (idx == 15), (fd_first && cyc == 0));
      end
      step();
      if (rdy) idx++;
      cyc++;
    end
    sif.m_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (idx != 16) begin
      errors++;
      $display("FAIL drain_timeout: delivered=%0d, need 16", idx);
    end
    checks++;
    if (sif.m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit: m_valid=%b busy=%b, need 0 0", sif.m_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (sif.m_valid !== 1'b0 || sif.m_last !== 1'b0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || ovf_err !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: v=%b last=%b busy=%b fd=%b ovf=%b cnt=%0d, need all 0",
               sif.m_valid, sif.m_last, busy, frame_done, ovf_err, frame_cnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    capture_frame(0, 1'b0);
    drain_frame(1'b0, 1'b1, 1'b0);
    checks++;
    if (frame_cnt !== 8'd1 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: cnt=%0d ovf=%b, need 1 0", frame_cnt, ovf_err);
    end
  endtask

  task automatic test_stall();
    do_reset();
    capture_frame(0, 1'b0);
    drain_frame(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_gaps();
    do_reset();
    capture_frame(1, 1'b1);
    drain_frame(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    do_reset();
    capture_frame(0, 1'b0);
    sif.m_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data = 32'hDEAD_0000 + 32'(k);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (ovf_err !== 1'b1 || sif.m_valid !== 1'b1 || sif.m_index !== 4'd0 ||
        sif.m_data !== exp_q[0] || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ovf_hold: ovf=%b v=%b idx=%0d data=%h cnt=%0d, need 1 1 0 %h 1",
               ovf_err, sif.m_valid, sif.m_index, sif.m_data, frame_cnt, exp_q[0]);
    end
    drain_frame(1'b0, 1'b0, 1'b0);
    checks++;
    if (ovf_err !== 1'b1 || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b cnt=%0d, need 1 1", ovf_err, frame_cnt);
    end
  endtask

  task automatic test_ovf_last();
    do_reset();
    capture_frame(2, 1'b0);
    drain_frame(1'b0, 1'b1, 1'b1);
    checks++;
    if (ovf_err !== 1'b1 || busy !== 1'b0 || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ovf_last: ovf=%b busy=%b cnt=%0d, need 1 0 1",
               ovf_err, busy, frame_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    capture_frame(0, 1'b0);
    sif.m_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k == 2);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (sif.m_index !== 4'd7 || ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: idx=%0d ovf=%b, need 7 1", sif.m_index, ovf_err);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    sif.m_ready = 1'b0;
    checks++;
    if (sif.m_valid !== 1'b0 || busy !== 1'b0 || ovf_err !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: v=%b busy=%b ovf=%b cnt=%0d, need 0 0 0 0",
               sif.m_valid, busy, ovf_err, frame_cnt);
    end
    capture_frame(2, 1'b0);
    drain_frame(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      capture_frame(f, 1'b0);
      drain_frame(1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (frame_cnt !== 8'd3 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: cnt=%0d ovf=%b, need 3 0", frame_cnt, ovf_err);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int f = 0; f < 256; f++) begin
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
        in_data = 32'(k);
        step();
      end
      in_valid = 1'b0;
      sif.m_ready = 1'b1;
      for (int k = 0; k < 16; k++) step();
      sif.m_ready = 1'b0;
      if (f == 254) begin
        checks++;
        if (frame_cnt !== 8'd255) begin
          errors++;
          $display("FAIL cnt_255: cnt=%0d, need 255", frame_cnt);
        end
      end
    end
    checks++;
    if (frame_cnt !== 8'd255 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cnt_saturate: cnt=%0d busy=%b, need 255 0", frame_cnt, busy);
    end
  endtask

  initial begin
    sif.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_overflow();
    test_ovf_last();
    test_mid_reset();
    test_back_to_back();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
